pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register: the general successor of the fixed IF/ID latch, used between any two stages of the RV32IM pipeline. It carries a DATA_W-bit payload with a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, a legacy-style Stall hold, and a synchronous Flush that injects a bubble. Instances sit at IF/ID, ID/EX, EX/MEM and MEM/WB, with the payload bundled by the instantiating stage.

---
 rtl/pipe_stage_reg.sv | 80 ++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage with two-entry skid; 1-cycle latency, 1 beat/cycle sustained.
// Backpressure: in_ready is registered (= skid empty), so out_ready/Stall never reach it combinationally.
module pipe_stage_reg #(
    parameter int                 DATA_W         = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_PAYLOAD = DATA_W'(32'h0000_0013)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              Stall,
    input  logic              Flush
);

    // Bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_d;
    logic [DATA_W-1:0] r_skid_d;

    logic w_in_xfer;
    logic w_out_xfer;

    assign in_ready   = ~r_state[1];
    assign out_valid  = r_state[0];
    assign out_data   = r_main_d;

    assign w_in_xfer  = in_valid & ~r_state[1];
    assign w_out_xfer = r_state[0] & out_ready & ~Stall;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_EMPTY;
            r_main_d <= BUBBLE_PAYLOAD;
            r_skid_d <= BUBBLE_PAYLOAD;
        end else if (Flush) begin
            // A beat handshaken this cycle is consumed upstream and dropped here.
            r_state  <= ST_EMPTY;
            r_main_d <= BUBBLE_PAYLOAD;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state  <= ST_FULL;
                        r_main_d <= in_data;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_d <= in_data;
                    end else if (w_in_xfer) begin
                        r_state  <= ST_SKID;
                        r_skid_d <= in_data;
                    end else if (w_out_xfer) begin
                        r_state  <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        r_state  <= ST_FULL;
                        r_main_d <= r_skid_d;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, hand sequences, and random traffic against a queue model.
module tb_pipe_stage_reg;

    localparam int          DW  = 96;
    localparam logic [DW-1:0] BUB = 96'h13;

    logic          CLK;
    logic          RESET_N;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          Stall;
    logic          Flush;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .Stall     (Stall),
        .Flush     (Flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the stage is a FIFO of depth 2; out_data shows the head, or the last beat to leave.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;

    function automatic void m_reset();
        mq.delete();
        m_last = BUB;
    endfunction

    function automatic void m_step(input logic iv, input logic [DW-1:0] id,
                                   input logic ordy, input logic st, input logic fl);
        bit ox;
        bit ix;
        if (fl) begin
            mq.delete();
            m_last = BUB;
        end else begin
            ox = (mq.size() > 0) && ordy && !st;
            ix = iv && (mq.size() < 2);
            if (ox) m_last = mq.pop_front();
            if (ix) mq.push_back(id);
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ov"}, DW'(out_valid), DW'(mq.size() > 0));
        chk({tag, "_od"}, out_data, (mq.size() > 0) ? mq[0] : m_last);
        chk({tag, "_ir"}, DW'(in_ready), DW'(mq.size() < 2));
    endtask

    // Called at a negedge: drive inputs, cross one rising edge, return at the next negedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic st, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        Stall     = st;
        Flush     = fl;
        m_step(iv, id, ordy, st, fl);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          st;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic ordy,
                                input logic st, input logic fl, input logic e_ov,
                                input logic [DW-1:0] e_od, input logic e_ir);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.st = st; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    initial begin
        //            iv  id         ordy st fl  e_ov e_od      e_ir
        tbl.push_back(mk(1, 96'h11,  1,   0, 0,  1,   96'h11,   1)); // A into FULL
        tbl.push_back(mk(1, 96'h22,  0,   0, 0,  1,   96'h11,   0)); // B into skid
        tbl.push_back(mk(1, 96'h33,  0,   0, 0,  1,   96'h11,   0)); // C waits
        tbl.push_back(mk(1, 96'h33,  0,   0, 0,  1,   96'h11,   0));
        tbl.push_back(mk(1, 96'h33,  1,   0, 0,  1,   96'h22,   1)); // skid drains, C not taken
        tbl.push_back(mk(1, 96'h33,  1,   0, 0,  1,   96'h33,   1));
        tbl.push_back(mk(0, 96'h0,   1,   0, 0,  0,   96'h33,   1));
        tbl.push_back(mk(1, 96'hABC, 1,   0, 0,  1,   96'hABC,  1)); // stall sequence
        tbl.push_back(mk(1, 96'hDEF, 1,   1, 0,  1,   96'hABC,  0));
        tbl.push_back(mk(1, 96'h777, 1,   1, 0,  1,   96'hABC,  0));
        tbl.push_back(mk(0, 96'h0,   1,   1, 0,  1,   96'hABC,  0));
        tbl.push_back(mk(0, 96'h0,   1,   1, 0,  1,   96'hABC,  0));
        tbl.push_back(mk(0, 96'h0,   1,   0, 0,  1,   96'hDEF,  1));
        tbl.push_back(mk(0, 96'h0,   1,   0, 0,  0,   96'hDEF,  1));
        tbl.push_back(mk(1, 96'h44,  0,   0, 0,  1,   96'h44,   1)); // flush in SKID
        tbl.push_back(mk(1, 96'h45,  0,   0, 0,  1,   96'h44,   0));
        tbl.push_back(mk(1, 96'h55,  0,   0, 1,  0,   BUB,      1));
        tbl.push_back(mk(0, 96'h0,   1,   0, 0,  0,   BUB,      1));
        tbl.push_back(mk(1, 96'h66,  1,   0, 0,  1,   96'h66,   1)); // flush + stall
        tbl.push_back(mk(1, 96'h67,  1,   1, 0,  1,   96'h66,   0));
        tbl.push_back(mk(1, 96'h68,  1,   1, 1,  0,   BUB,      1));
        tbl.push_back(mk(1, 96'h69,  1,   0, 0,  1,   96'h69,   1));
        tbl.push_back(mk(1, 96'h70,  0,   0, 1,  0,   BUB,      1)); // handshaken beat dropped
        tbl.push_back(mk(0, 96'h0,   1,   0, 0,  0,   BUB,      1));

        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        Stall     = 1'b0;
        Flush     = 1'b0;
        m_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ov", DW'(out_valid), DW'(0));
        chk("rst_od", out_data, BUB);
        chk("rst_ir", DW'(in_ready), DW'(1));
        RESET_N = 1'b1;

        // Streaming: each beat on the output one cycle after acceptance.
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("strm%0d_ir_pre", k), DW'(in_ready), DW'(1));
            cycle(1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
            chk($sformatf("strm%0d_ov", k), DW'(out_valid), DW'(1));
            chk($sformatf("strm%0d_od", k), out_data, DW'(k));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk_model("strm_drain");

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].st, tbl[i].fl);
            chk($sformatf("tbl%0d_ov", i), DW'(out_valid), DW'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_od", i), out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d_ir", i), DW'(in_ready), DW'(tbl[i].e_ir));
            chk_model($sformatf("tbl%0d_m", i));
        end

        // Asynchronous reset between edges while two beats are held.
        cycle(1'b1, 96'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 96'hA2, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_ir", DW'(in_ready), DW'(0));
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        m_reset();
        #1;
        chk("arst_ov", DW'(out_valid), DW'(0));
        chk("arst_od", out_data, BUB);
        chk("arst_ir", DW'(in_ready), DW'(1));
        @(negedge CLK);
        in_valid = 1'b0;
        RESET_N  = 1'b1;
        cycle(1'b1, 96'h99, 1'b1, 1'b0, 1'b0);
        chk("post_arst_ov", DW'(out_valid), DW'(1));
        chk("post_arst_od", out_data, 96'h99);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk_model("post_arst_drain");

        // Random traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 31) == 0));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
